// File: rtl/free_list.sv
// Free-block pool: circular FIFO of buffer block indices, self-filled after reset.
// Optional FL_DOUBLE_FREE_CHECK_EN adds an in-pool bitmap that rejects double frees.
module free_list #(
    parameter int NUM_BLOCKS = 1024,
    parameter int ADDR_W     = $clog2(NUM_BLOCKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req_i,
    output logic              alloc_gnt_o,
    output logic [ADDR_W-1:0] alloc_block_idx_o,
    input  logic              free_req_i,
    input  logic [ADDR_W-1:0] free_block_idx_i,
    output logic [ADDR_W:0]   free_cnt_o,
    output logic              empty_o,
    output logic              init_done_o,
    output logic              err_o
);

    localparam logic [ADDR_W:0]   FULL = (ADDR_W+1)'(NUM_BLOCKS);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BLOCKS - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_ctr_q, init_ctr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] mem [NUM_BLOCKS];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ADDR_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] rd_data;

    logic run;
    logic alloc_ok;
    logic free_ok;
    logic dup;

    assign rd_data  = mem[rd_ptr_q];
    assign run      = (state_q == ST_RUN);
    // Alloc uses the pre-update count: no bypass of a same-cycle free.
    assign alloc_ok = run && alloc_req_i && (count_q != '0);
    // A same-cycle alloc opens a slot, so a free into a full pool is fine.
    assign free_ok  = run && free_req_i && !dup &&
                      ((count_q != FULL) || alloc_ok);

`ifdef FL_DOUBLE_FREE_CHECK_EN
    logic [NUM_BLOCKS-1:0] in_pool_q, in_pool_d;

    // A grant of the same index in this cycle clears its bit first.
    assign dup = in_pool_q[free_block_idx_i] &&
                 !(alloc_ok && (rd_data == free_block_idx_i));

    // Bitmap: all set at end of init, cleared on grant, set on free.
    always_comb begin
        in_pool_d = in_pool_q;
        if (state_q == ST_INIT && init_ctr_q == LAST) begin
            in_pool_d = '1;
        end
        if (alloc_ok) begin
            in_pool_d[rd_data] = 1'b0;
        end
        if (free_ok) begin
            in_pool_d[free_block_idx_i] = 1'b1;
        end
    end

    // Bitmap register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pool_q <= '0;
        end else begin
            in_pool_q <= in_pool_d;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Next-state: init fill, then alloc/free bookkeeping.
    always_comb begin
        state_d    = state_q;
        init_ctr_d = init_ctr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        gnt_d      = 1'b0;
        idx_d      = idx_q;
        done_d     = done_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_ptr_q;
        mem_wdata  = free_block_idx_i;
        unique case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_ctr_q;
                mem_wdata  = init_ctr_q;
                init_ctr_d = init_ctr_q + ADDR_W'(1);
                if (free_req_i) begin
                    err_d = 1'b1;
                end
                if (init_ctr_q == LAST) begin
                    count_d = FULL;
                    done_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (alloc_ok) begin
                    gnt_d    = 1'b1;
                    idx_d    = rd_data;
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                end
                if (free_ok) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                end
                if (free_req_i && !free_ok) begin
                    err_d = 1'b1;
                end
                case ({alloc_ok, free_ok})
                    2'b10:   count_d = count_q - (ADDR_W+1)'(1);
                    2'b01:   count_d = count_q + (ADDR_W+1)'(1);
                    default: count_d = count_q;
                endcase
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_ctr_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            gnt_q      <= 1'b0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ctr_q <= init_ctr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            gnt_q      <= gnt_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Index storage; contents are rebuilt by init after every reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign alloc_gnt_o       = gnt_q;
    assign alloc_block_idx_o = idx_q;
    assign free_cnt_o        = count_q;
    assign empty_o           = (count_q == '0);
    assign init_done_o       = done_q;
    assign err_o             = err_q;

endmodule
